mem_responder: RTL and testbench

Memory-side responder for the multi-cycle core's memory port. It decodes each core access into a word RAM or a small I/O register bank (LEDs, free-running cycle counter, UART transmitter) and returns read data one clock after the request. It sits between the core and the board pins in the top level.

---
 rtl/mem_map_pkg.sv | 9 +
 rtl/uart_tx_serializer.sv | 52 +++++
 rtl/mem_responder.sv | 64 ++++++
 tb/tb_mem_responder.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// mem_map_pkg: memory map constants and UART state type shared by the responder
package mem_map_pkg;
  localparam int IO_SEL_BIT = 22;
  localparam logic [2:0] IO_LED       = 3'd0;
  localparam logic [2:0] IO_CYCLES    = 3'd1;
  localparam logic [2:0] IO_UART_DATA = 3'd2;
  localparam logic [2:0] IO_UART_STAT = 3'd3;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 transmitter, accepts a new byte on the last clock of the stop bit
module uart_tx_serializer
  import mem_map_pkg::*;
#(
  parameter int BAUD_DIV = 104
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
  uart_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  logic tx_n, last;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
      tx    <= tx_n;
    end
  end
  always_comb begin
    last    = cnt == LAST;
    state_n = state;
    cnt_n   = (state == IDLE || last) ? '0 : cnt + 1'b1;
    idx_n   = idx;
    sh_n    = sh;
    case (state)
      IDLE:  if (start) begin state_n = START; sh_n = data; end
      START: if (last) begin state_n = DATA; idx_n = '0; end
      DATA:  if (last) begin sh_n = sh >> 1; idx_n = idx + 1'b1; state_n = idx == 3'd7 ? STOP : DATA; end
      STOP:  if (last) begin state_n = start ? START : IDLE; sh_n = start ? data : sh; end
      default: state_n = IDLE;
    endcase
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : 1'b1;
  end
  assign busy = state != IDLE;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: core memory port to word RAM plus LED/cycle/UART I/O bank; UART built only when MEM_RESP_UART_EN is defined
module mem_responder
  import mem_map_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int BAUD_DIV    = 104
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] mem_addr,
  input  logic        mem_r_enable,
  input  logic        mem_w_enable,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic [7:0]  leds,
  output logic        uart_tx
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [31:0] ram [DEPTH_WORDS];
  logic [31:0] ram_q, io_q, io_rd, cycles;
  logic [AW-1:0] widx;
  logic [2:0] off;
  logic io_sel, rd_io, busy, unused_addr;
  assign io_sel      = mem_addr[IO_SEL_BIT];
  assign widx        = mem_addr[2 +: AW];
  assign off         = mem_addr[4:2];
  assign unused_addr = ^mem_addr;
  assign io_rd = off == IO_LED       ? {24'd0, leds} :
                 off == IO_CYCLES    ? cycles :
                 off == IO_UART_STAT ? {31'd0, busy} : 32'd0;
  always_ff @(posedge clk) begin
    if (reset_n && mem_w_enable && !io_sel) ram[widx] <= mem_wdata;
    if (mem_r_enable) ram_q <= ram[widx];
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cycles <= '0;
      leds   <= '0;
      io_q   <= '0;
      rd_io  <= 1'b1;
    end else begin
      cycles <= cycles + 32'd1;
      if (mem_w_enable && io_sel && off == IO_LED) leds <= mem_wdata[7:0];
      if (mem_r_enable) begin
        rd_io <= io_sel;
        io_q  <= io_rd;
      end
    end
  end
  assign mem_rdata = rd_io ? io_q : ram_q;
`ifdef MEM_RESP_UART_EN
  uart_tx_serializer #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mem_w_enable && io_sel && off == IO_UART_DATA),
    .data    (mem_wdata[7:0]),
    .busy    (busy),
    .tx      (uart_tx)
  );
`else
  assign busy    = 1'b0;
  assign uart_tx = 1'b1;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: random and directed stimulus checked against a behavioural memory-map model
module tb_mem_responder;
  localparam int B = 4;
`ifdef MEM_RESP_UART_EN
  localparam bit UART_ON = 1'b1;
`else
  localparam bit UART_ON = 1'b0;
`endif
  logic clk = 0, reset_n = 0, re = 0, we = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [31:0] mem_rdata;
  logic [7:0] leds;
  logic uart_tx;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  mem_responder #(.DEPTH_WORDS(1024), .BAUD_DIV(B)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_addr     (addr),
    .mem_r_enable (re),
    .mem_w_enable (we),
    .mem_wdata    (wdata),
    .mem_rdata    (mem_rdata),
    .leds         (leds),
    .uart_tx      (uart_tx)
  );
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  logic [31:0] m_ram [1024];
  bit m_known [1024];
  logic [31:0] m_rdata, m_cyc;
  logic [7:0] m_leds, f_byte;
  bit m_rd_ok, m_init, f_valid, m_tx, io;
  int n = 0, e0 = 0, w, off, k;
  initial forever begin
    @(posedge clk);
    n++;
    if (!reset_n) begin
      m_init = 1; m_rdata = 0; m_rd_ok = 1; m_leds = 0; m_cyc = 0; f_valid = 0;
    end else begin
      w = int'(addr[11:2]); off = int'(addr[4:2]); io = addr[22];
      if (re) begin
        m_rd_ok = io || m_known[w];
        m_rdata = !io ? m_ram[w] : off == 0 ? {24'd0, m_leds} : off == 1 ? m_cyc :
                  off == 3 ? {31'd0, UART_ON && f_valid && (n - e0 <= 10 * B)} : 32'd0;
      end
      if (we) begin
        if (!io) begin m_ram[w] = wdata; m_known[w] = 1; end
        else if (off == 0) m_leds = wdata[7:0];
        else if (off == 2 && UART_ON && (!f_valid || n - e0 >= 10 * B)) begin
          f_valid = 1; e0 = n; f_byte = wdata[7:0];
        end
      end
      m_cyc++;
    end
    k = n - e0;
    m_tx = !(f_valid && k < 10 * B) ? 1'b1 : k / B == 0 ? 1'b0 : k / B == 9 ? 1'b1 : f_byte[k / B - 1];
  end
  initial forever begin
    @(negedge clk);
    if (m_init) begin
      check("model_leds", leds, m_leds);
      check("model_tx", uart_tx, m_tx);
      if (m_rd_ok) check("model_rdata", mem_rdata, m_rdata);
    end
  end
  task automatic drive(input bit rn, input bit r, input bit wr, input logic [31:0] a, input logic [31:0] d);
    reset_n = rn; re = r; we = wr; addr = a; wdata = d;
    @(negedge clk);
  endtask
  logic [9:0] pat;
  logic [31:0] v1, ra;
  bit rr, ww;
  initial begin
    pat = {1'b1, 8'h55, 1'b0};
    @(negedge clk);
    drive(0, 1, 1, 32'h10, 32'h5);
    drive(0, 0, 0, 0, 0);
    check("rst_rdata", mem_rdata, 0);
    check("rst_leds", leds, 0);
    check("rst_tx", uart_tx, 1);
    drive(1, 0, 1, 32'h10, 32'hDEADBEEF);
    drive(1, 1, 0, 32'h10, 0);
    check("ram_rd", mem_rdata, 32'hDEADBEEF);
    drive(1, 0, 1, 32'h1004, 32'h12345678);
    drive(1, 1, 0, 32'h4, 0);
    check("alias", mem_rdata, 32'h12345678);
    drive(1, 0, 1, 32'h20, 32'h11);
    drive(1, 1, 1, 32'h20, 32'h22);
    check("rbw_old", mem_rdata, 32'h11);
    drive(1, 1, 0, 32'h20, 0);
    check("rbw_new", mem_rdata, 32'h22);
    drive(1, 0, 0, 32'h10, 0);
    check("hold", mem_rdata, 32'h22);
    drive(1, 0, 1, 32'h0040_0000, 32'hABCD_01F5);
    check("leds", leds, 8'hF5);
    drive(1, 1, 0, 32'h0040_0000, 0);
    check("led_rd", mem_rdata, 32'hF5);
    drive(0, 0, 0, 0, 0);
    check("rst2_leds", leds, 0);
    check("rst2_rdata", mem_rdata, 0);
    drive(1, 1, 0, 32'h0040_0004, 0);
    v1 = mem_rdata;
    check("cyc_after_rst", v1, 0);
    repeat (4) drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 32'h0040_0004, 0);
    check("cyc_delta", mem_rdata - v1, 5);
    drive(1, 0, 1, 32'h0040_0008, 32'h55);
    check("tx_start", uart_tx, UART_ON ? 1'b0 : 1'b1);
    for (int t = 1; t <= 44; t++) begin
      drive(1, t == 3 || t == 41, t == 10, t == 10 ? 32'h0040_0008 : 32'h0040_000C, 32'hAA);
      check("tx_bit", uart_tx, (UART_ON && t < 40) ? pat[t / 4] : 1'b1);
      if (t == 3) check("stat_busy", mem_rdata, {31'd0, UART_ON});
      if (t == 41) check("stat_idle", mem_rdata, 0);
    end
    drive(1, 0, 1, 32'h0040_0008, 32'h55);
    for (int t = 1; t < 20; t++) drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("rst_mid_tx", uart_tx, 1);
    drive(1, 1, 0, 32'h0040_000C, 0);
    check("rst_mid_busy", mem_rdata, 0);
    for (int i = 0; i < 3000; i++) begin
      ra = $urandom;
      if ($urandom % 5 < 2) begin
        ra[31:23] = '0; ra[22] = 1'b1; ra[21:5] = '0;
      end else begin
        ra[22] = 1'b0; ra[11:2] = 10'($urandom % 16);
      end
      rr = $urandom % 2 == 0;
      ww = $urandom % 2 == 0;
      drive($urandom % 250 != 0, rr, ww, ra, $urandom);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
